// File: rtl/parallel_serial.sv
// Transmit-side serializer: sends a comma burst after reset, then 10-bit symbols MSB-first,
// filling every idle slot with K28.5 commas of alternating disparity.
module parallel_serial #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] COMMA_NEG  = 10'b0011111010,
  parameter logic [WIDTH-1:0] COMMA_POS  = 10'b1100000101,
  parameter int               SYNC_COUNT = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             DATA_OUT,
  output logic             SYMBOL_START,
  output logic             ACTIVE
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(SYNC_COUNT + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_COUNT - 1);

  typedef enum logic {SYNC, LINK} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    sync_q;
  logic             rd_q;
  logic             active_q;
  logic             sos_q;
  logic             load;

  // Handshake: a symbol transfers on the rising edge where VALID_IN && READY_OUT.
  // READY_OUT depends only on registers, so the upstream may hold VALID_IN freely.
  assign load         = (cnt_q == LAST_BIT);
  assign READY_OUT    = (state_q == LINK) && load;
  assign DATA_OUT     = shift_q[WIDTH-1];
  assign SYMBOL_START = sos_q;
  assign ACTIVE       = active_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= SYNC;
      shift_q  <= '0;
      cnt_q    <= LAST_BIT;
      sync_q   <= '0;
      rd_q     <= 1'b0;
      active_q <= 1'b0;
      sos_q    <= 1'b0;
    end else if (load) begin
      cnt_q <= '0;
      sos_q <= 1'b1;
      if (state_q == LINK && VALID_IN) begin
        shift_q  <= DATA_IN;
        active_q <= 1'b1;
      end else begin
        // Only commas flip disparity; data disparity belongs to the upstream encoder.
        shift_q  <= rd_q ? COMMA_POS : COMMA_NEG;
        active_q <= 1'b0;
        rd_q     <= ~rd_q;
        if (state_q == SYNC) begin
          sync_q <= sync_q + SW'(1);
          if (sync_q == LAST_SYNC) state_q <= LINK;
        end
      end
    end else begin
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q + CW'(1);
      sos_q   <= 1'b0;
    end
  end

endmodule
